// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, funct3 codes and access-size decode for the data-memory responder
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - request/response handshake bundle between core and data-memory responder
interface data_mem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single-port word RAM with byte write enables and registered read data
module dm_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // rdata only updates on an enabled read, so it holds while the responder waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (|be) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - load/store responder: error decode, byte-lane steering and load formatting
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  data_mem_resp_if.slave    bus
);

  state_t        state, state_nx;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  size_t         req_sz, sz_q;
  logic          req_err;
  logic          hs;

  logic          ram_en;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   sh;
  logic [31:0]   fmt;

  assign hs = bus.req_valid && (state == IDLE);

  always_comb begin
    req_sz  = f3_size(bus.req_funct3);
    req_err = (req_sz == SZ_BAD)
           || (bus.req_we && bus.req_funct3[2])
           || ((req_sz == SZ_H) && bus.req_addr[0])
           || ((req_sz == SZ_W) && (bus.req_addr[1:0] != 2'b00))
           || (bus.req_addr[31:2] >= 30'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (hs) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[AW+1:0];
      wdata_q <= bus.req_wdata;
      err_q   <= req_err;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (hs) state_nx = req_err ? RESP : ACCESS;
      end
      ACCESS: state_nx = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (err_q || we_q) ? 32'h0 : fmt;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Errored requests skip ACCESS, so the RAM is only ever enabled for legal ones
  always_comb begin
    sz_q      = f3_size(f3_q);
    ram_en    = (state == ACCESS);
    ram_be    = 4'b0000;
    ram_wdata = wdata_q;
    case (sz_q)
      SZ_B: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      SZ_W:    ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
    if (!we_q) ram_be = 4'b0000;
  end

  always_comb begin
    sh  = ram_rdata >> {addr_q[1:0], 3'b000};
    fmt = 32'h0;
    case (sz_q)
      SZ_B:    fmt = f3_q[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    fmt = f3_q[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    fmt = ram_rdata;
      default: fmt = 32'h0;
    endcase
  end

  dm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (addr_q[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - randomized self-checking bench for data_mem_resp with a byte-array reference
module tb_data_mem_resp;
  import mem_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  data_mem_resp_if bus();

  data_mem_resp #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_b [4*DEPTH];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rdy_mode = 0;
  bit         cmp_on = 0;
  bit         ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory, sizes and legality straight from the access rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int sz;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    err = (sz == 0) || (we && f3[2]) || (addr >= 32'(4*DEPTH));
    if (!err && ((addr % 32'(sz)) != 0)) err = 1'b1;
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mem_b[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_b[addr + 32'(i)];
        if (!f3[2] && sz < 4 && v[8*sz-1]) begin
          for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit pin,
                      input logic [31:0] pin_rd, input logic pin_err);
    exp_t e;
    int n;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e.hs = cyc;
    model(we, f3, addr, wdata, e.rd, e.err);
    e.lat = e.err ? 1 : 2;
    if (pin) begin
      chk("model_rd", e.rd, pin_rd);
      chk("model_err", {31'b0, e.err}, {31'b0, pin_err});
    end
    @(posedge clk); #1;
    exp_q.push_back(e);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always begin
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = 1'($urandom);
      default: bus.rsp_ready = 1'b0;
    endcase
    @(posedge clk); #1;
  end

  always @(negedge clk) begin
    if (cmp_on && rst) begin
      ev = (exp_q.size() != 0) && (cyc >= exp_q[0].hs + exp_q[0].lat);
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_q.size() == 0});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, ev});
      if (ev) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rd);
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_q[0].err});
        if (bus.rsp_valid && bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] ra;
    logic [2:0]  rf;
    logic [2:0]  legal [5];
    logic [31:0] old;
    int n;
    legal[0] = F3_B; legal[1] = F3_H; legal[2] = F3_W; legal[3] = F3_BU; legal[4] = F3_HU;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cmp_on = 1'b1;

    send(1, F3_W, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
    send(0, F3_W, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    for (int w = 0; w < DEPTH; w++) begin
      if (w != 4) send(1, F3_W, 32'(4*w), $urandom, 0, 32'h0, 0);
    end

    send(0, F3_B,  32'h13, 32'h0, 1, 32'hFFFFFFDE, 0);
    send(0, F3_BU, 32'h13, 32'h0, 1, 32'h000000DE, 0);
    send(0, F3_H,  32'h10, 32'h0, 1, 32'hFFFFBEEF, 0);
    send(0, F3_HU, 32'h12, 32'h0, 1, 32'h0000DEAD, 0);

    send(1, F3_B, 32'h11, 32'hABCDEF55, 1, 32'h0, 0);
    send(0, F3_W, 32'h10, 32'h0, 1, 32'hDEAD55EF, 0);
    send(1, F3_H, 32'h12, 32'h99991234, 1, 32'h0, 0);
    send(0, F3_W, 32'h10, 32'h0, 1, 32'h123455EF, 0);

    send(0, F3_H,   32'h11, 32'h0, 1, 32'h0, 1);
    send(0, F3_W,   32'h12, 32'h0, 1, 32'h0, 1);
    send(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1);
    send(0, F3_W,   32'(4*DEPTH), 32'h0, 1, 32'h0, 1);
    send(1, F3_W,   32'h12, 32'h11111111, 1, 32'h0, 1);
    send(1, F3_BU,  32'h10, 32'h22222222, 1, 32'h0, 1);
    send(1, F3_H,   32'h13, 32'h33333333, 1, 32'h0, 1);
    send(0, F3_W,   32'h10, 32'h0, 1, 32'h123455EF, 0);

    // Response stall with a stray request that must be ignored
    drain();
    rdy_mode = 2;
    send(0, F3_W, 32'h10, 32'h0, 1, 32'h123455EF, 0);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("stall_rdata_hold", bus.rsp_rdata, 32'h123455EF);
    chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rdy_mode = 0;
    drain();
    send(0, F3_W, 32'h10, 32'h0, 1, 32'h123455EF, 0);

    // Reset while a store sits in ACCESS
    send(1, F3_W, 32'h20, 32'h01234567, 0, 32'h0, 0);
    send(0, F3_W, 32'h20, 32'h0, 1, 32'h01234567, 0);
    drain();
    for (int i = 0; i < 4; i++) old[8*i +: 8] = mem_b[32 + i];
    send(1, F3_W, 32'h20, 32'hAAAAAAAA, 0, 32'h0, 0);
    #2 rst = 1'b0;
    cmp_on = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("async_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("async_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("async_rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) mem_b[32 + i] = old[8*i +: 8];
    @(posedge clk); #1;
    rst = 1'b1;
    cmp_on = 1'b1;
    send(0, F3_W, 32'h20, 32'h0, 1, 32'h01234567, 0);

    rdy_mode = 1;
    repeat (300) begin
      rf = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
      if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
      send(1'($urandom), rf, ra, $urandom, 0, 32'h0, 0);
    end
    drain();

    rdy_mode = 0;
    for (int w = 0; w < DEPTH; w++) send(0, F3_W, 32'(4*w), 32'h0, 0, 32'h0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
